m_load_unit: RTL and testbench
==============================

M_LOAD_UNIT -- requirements
Module: m_load_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set max cycles waiting for mem_rvalid before abort.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-004 ld_valid  input  1  pipeline load request.
REQ-005 ld_op  input  3  1=lw, 2=lh, 3=lhu, 4=lb, 5=lbu; others illegal.
REQ-006 ld_addr  input  32  byte address.
REQ-007 ld_ready  output  1  unit idle, request accepted this cycle if ld_valid.
REQ-008 stall  output  1  pipeline freeze, high from acceptance until wb_valid cycle inclusive.
REQ-009 mem_req / mem_addr  output  1 / 32  read request; mem_addr = {captured addr[31:2], 2'b00}.
REQ-010 mem_gnt  input  1  memory accepted request.
REQ-011 mem_rvalid / mem_rdata  input  1 / 32  read data return.
REQ-012 wb_valid / wb_data / ld_err  output  1 / 32 / 1  one-cycle writeback result and error flag.

Function
REQ-013 FSM states IDLE, REQ, WAIT, RESP; ld_ready SHALL be 1 only in IDLE.
REQ-014 IDLE with ld_valid=1: capture ld_op, ld_addr; go to REQ (or RESP with ld_err if illegal op, no memory access).
REQ-015 REQ: mem_req=1, mem_addr stable until mem_gnt=1; gnt without rvalid -> WAIT; gnt with rvalid same cycle -> RESP.
REQ-016 WAIT: on mem_rvalid -> RESP, capture mem_rdata; wait counter increments each cycle.
REQ-017 WAIT counter reaching TIMEOUT_CYCLES -> RESP with ld_err=1, wb_data=0.
REQ-018 RESP: wb_valid=1 exactly one cycle, then IDLE; minimum latency acceptance->wb_valid = 2 cycles.
REQ-019 Little-endian extraction: lw = word; lh/lhu select [15:0] if addr[1]=0 else [31:16]; lb/lbu select byte addr[1:0] (0 -> [7:0] ... 3 -> [31:24]).
REQ-020 lh/lb SHALL sign-extend to 32 bits; lhu/lbu SHALL zero-extend.
REQ-021 mem_rvalid in IDLE or REQ-without-gnt SHALL be ignored (stale response).
REQ-022 wb_data SHALL hold last value when wb_valid=0; ld_err=0 except in error RESP cycle.

Reset
REQ-023 reset=0 at an edge SHALL force IDLE, counter 0, captured regs 0, from any state, dropping any outstanding access.
REQ-024 Reset values: ld_ready=1, stall=0, mem_req=0, mem_addr=0, wb_valid=0, wb_data=0, ld_err=0.

Configuration
REQ-025 Macro LOAD_ALIGN_CHECK_EN defined: lw with addr[1:0]!=0 or lh/lhu with addr[0]=1 SHALL skip memory, go to RESP next cycle, ld_err=1, wb_data=0.
REQ-026 Macro undefined: no alignment check; lw ignores addr[1:0], lh/lhu ignore addr[0].

Structure
REQ-027 Shared package SHALL hold ld_op encodings and FSM state enum, reused by decode stage.
REQ-028 Sub-module load_extract (combinational: op, addr[1:0], rdata -> extended data) SHALL hold REQ-019/020.

Verification
REQ-029 lb addr 0x0000_1003, rdata 0x80AB_CDEF, gnt+rvalid same cycle -> wb_data 0xFFFF_FF80, wb_valid 2 cycles after acceptance.
REQ-030 lhu addr 0x0000_2002, rdata 0x8001_1234, gnt 3 cycles late, rvalid 2 after -> wb_data 0x0000_8001, stall high throughout, mem_addr 0x0000_2000.
REQ-031 lw addr 0x10, no rvalid -> after 255 WAIT cycles ld_err=1, wb_data 0, then ld_ready=1.
REQ-032 reset=0 during WAIT, later stale rvalid while IDLE -> no wb_valid, all outputs at reset values.
REQ-033 LOAD_ALIGN_CHECK_EN: lw addr 0x13 -> mem_req never asserted, ld_err=1 next cycle; undefined: mem_addr 0x10, full word returned.
REQ-034 ld_op=7 -> ld_err=1, mem_req stays 0.

Source files
------------

// File: rtl/m_load_unit_pkg.sv
// Shared load-unit definitions: load op encodings, FSM states and op classification helpers.
// Reused by the decode stage so both sides agree on ld_op values.
package m_load_unit_pkg;

    localparam logic [2:0] LD_LW  = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LHU = 3'd3;
    localparam logic [2:0] LD_LB  = 3'd4;
    localparam logic [2:0] LD_LBU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } ld_state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op >= LD_LW) && (op <= LD_LBU);
    endfunction

    function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        return ((op == LD_LW) && (addr_lo != 2'b00)) ||
               (((op == LD_LH) || (op == LD_LHU)) && addr_lo[0]);
    endfunction

endpackage

// File: rtl/load_extract.sv
// Little-endian lane selection and sign/zero extension of a returned memory word.
module load_extract
    import m_load_unit_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    always_comb begin
        o_data = '0;
        case (i_op)
            LD_LW:   o_data = i_rdata;
            LD_LH:   o_data = {{16{w_half[15]}}, w_half};
            LD_LHU:  o_data = {16'h0000, w_half};
            LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  o_data = {24'h000000, w_byte};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/m_load_unit.sv
// Single-outstanding load unit: request/grant/response handshake with wait timeout.
// Optional alignment trap enabled by defining LOAD_ALIGN_CHECK_EN.
module m_load_unit
    import m_load_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [2:0]  ld_op,
    input  logic [31:0] ld_addr,
    output logic        ld_ready,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        ld_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    ld_state_e        r_state;
    ld_state_e        w_next;
    logic [2:0]       r_op;
    logic [31:0]      r_addr;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_wb_data;
    logic             r_err;
    logic [31:0]      w_ext;
    logic             w_reject;
    logic             w_timeout;

`ifdef LOAD_ALIGN_CHECK_EN
    assign w_reject = !op_is_legal(ld_op) || op_misaligned(ld_op, ld_addr[1:0]);
`else
    assign w_reject = !op_is_legal(ld_op);
`endif

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    load_extract u_load_extract (
        .i_op      (r_op),
        .i_addr_lo (r_addr[1:0]),
        .i_rdata   (mem_rdata),
        .o_data    (w_ext)
    );

    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (ld_valid)                w_next = w_reject ? ST_RESP : ST_REQ;
            ST_REQ:  if (mem_gnt)                 w_next = mem_rvalid ? ST_RESP : ST_WAIT;
            ST_WAIT: if (mem_rvalid || w_timeout) w_next = ST_RESP;
            default:                              w_next = ST_IDLE;
        endcase
    end

    // Captured request and result; rejected or timed-out loads write back zero with an error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op      <= '0;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_wb_data <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (ld_valid) begin
                    r_op   <= ld_op;
                    r_addr <= ld_addr;
                    r_cnt  <= '0;
                    r_err  <= w_reject;
                    if (w_reject) r_wb_data <= '0;
                end
                ST_REQ: if (mem_gnt && mem_rvalid) begin
                    r_err     <= 1'b0;
                    r_wb_data <= w_ext;
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        r_err     <= 1'b0;
                        r_wb_data <= w_ext;
                    end else if (w_timeout) begin
                        r_err     <= 1'b1;
                        r_wb_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_err <= 1'b0;
            endcase
        end
    end

    always_comb begin
        ld_ready = 1'b0;
        stall    = 1'b1;
        mem_req  = 1'b0;
        wb_valid = 1'b0;
        ld_err   = 1'b0;
        mem_addr = {r_addr[31:2], 2'b00};
        wb_data  = r_wb_data;
        case (r_state)
            ST_IDLE: begin
                ld_ready = 1'b1;
                stall    = 1'b0;
            end
            ST_REQ:  mem_req = 1'b1;
            ST_RESP: begin
                wb_valid = 1'b1;
                ld_err   = r_err;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_m_load_unit.sv
// Self-checking bench for m_load_unit: directed corner cases plus randomized loads vs. a behavioural model.
module tb_m_load_unit;

    localparam int TO = 255;
`ifdef LOAD_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ld_valid = 1'b0;
    logic [2:0]  ld_op = 3'd0;
    logic [31:0] ld_addr = 32'd0;
    logic        ld_ready, stall, mem_req, wb_valid, ld_err;
    logic [31:0] mem_addr, wb_data;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int total = 0;
    int bad   = 0;

    m_load_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_op      (ld_op),
        .ld_addr    (ld_addr),
        .ld_ready   (ld_ready),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .ld_err     (ld_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Behavioural model: shift the addressed lane down, mask, then two's-complement adjust.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] v;
        v = 32'd0;
        case (op)
            3'd1: v = word;
            3'd2, 3'd3: begin
                v = (word >> (16 * int'(addr[1]))) & 32'h0000_FFFF;
                if (op == 3'd2 && v >= 32'h0000_8000) v = v - 32'h0001_0000;
            end
            3'd4, 3'd5: begin
                v = (word >> (8 * int'(addr[1:0]))) & 32'h0000_00FF;
                if (op == 3'd4 && v >= 32'h0000_0080) v = v - 32'h0000_0100;
            end
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    function automatic bit ref_reject(input logic [2:0] op, input logic [31:0] addr);
        bit illegal, mis;
        illegal = (op < 3'd1) || (op > 3'd5);
        mis = ((op == 3'd1) && (addr % 4 != 0)) || (((op == 3'd2) || (op == 3'd3)) && (addr % 2 != 0));
        return illegal || (ALIGN_EN && mis);
    endfunction

    function automatic bit reset_outputs_ok();
        return ld_ready === 1'b1 && stall === 1'b0 && mem_req === 1'b0 && mem_addr === 32'd0 &&
               wb_valid === 1'b0 && wb_data === 32'd0 && ld_err === 1'b0;
    endfunction

    // One load; rdly < 0 means the memory never answers. Called at posedge+1 while idle.
    task automatic run_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input int gdly, input int rdly, input logic [31:0] word);
        bit rej, tout, granted, done;
        int n_req, n_wait, lat, exp_lat;
        logic [31:0] exp_data, held;
        rej  = ref_reject(op, addr);
        tout = !rej && (rdly < 0);
        exp_data = (rej || tout) ? 32'd0 : ref_load(op, addr, word);
        exp_lat  = rej ? 1 : (tout ? gdly + 1 + TO + 1 : gdly + 1 + rdly + 1);
        granted = 1'b0; done = 1'b0; n_req = 0; n_wait = 0;

        chk({tag, " ready_idle"}, ld_ready, 1'b1);
        ld_valid = 1'b1; ld_op = op; ld_addr = addr;
        tick();
        ld_valid = 1'b0; ld_op = 3'($urandom); ld_addr = $urandom;
        lat = 1;
        for (int c = 0; c < 600; c++) begin
            if (wb_valid === 1'b1) begin
                done = 1'b1;
                break;
            end
            lat++;
            chk({tag, " stall_busy"}, stall, 1'b1);
            chk({tag, " ready_busy"}, ld_ready, 1'b0);
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (!granted && mem_req === 1'b1) begin
                chk({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
                if (n_req == gdly) begin
                    mem_gnt = 1'b1;
                    granted = 1'b1;
                    if (rdly == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = word;
                    end
                end else begin
                    mem_rvalid = 1'($urandom_range(0, 1));
                end
                n_req++;
            end else if (granted) begin
                chk({tag, " req_after_gnt"}, mem_req, 1'b0);
                n_wait++;
                if (rdly > 0 && n_wait == rdly) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = word;
                end
            end
            tick();
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        total++;
        assert (done)
        else begin
            bad++;
            $error("FAIL %s wb_timeout: observed=no wb_valid expected=wb_valid within bound", tag);
        end
        if (done) begin
            chk({tag, " wb_data"}, wb_data, exp_data);
            chk({tag, " ld_err"}, ld_err, 32'(rej || tout));
            chk({tag, " latency"}, lat, exp_lat);
            chk({tag, " mem_used"}, 32'(n_req > 0), 32'(!rej));
            chk({tag, " stall_wb"}, stall, 1'b1);
            held = wb_data;
            tick();
            chk({tag, " wb_one_cycle"}, wb_valid, 1'b0);
            chk({tag, " err_cleared"}, ld_err, 1'b0);
            chk({tag, " ready_after"}, ld_ready, 1'b1);
            chk({tag, " stall_after"}, stall, 1'b0);
            chk({tag, " wb_hold"}, wb_data, held);
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            tick();
            mem_rvalid = 1'b0;
            chk({tag, " stale_idle"}, wb_valid, 1'b0);
            chk({tag, " wb_hold2"}, wb_data, held);
        end
    endtask

    initial begin
        reset = 1'b0;
        tick(); tick();
        chk("reset_state", 32'(reset_outputs_ok()), 1);
        reset = 1'b1;
        tick();
        chk("reset_release", 32'(reset_outputs_ok()), 1);

        run_load("lb_signed",   3'd4, 32'h0000_1003, 0, 0, 32'h80AB_CDEF);
        chk("lb_value", wb_data, 32'hFFFF_FF80);
        run_load("lhu_late",    3'd3, 32'h0000_2002, 3, 2, 32'h8001_1234);
        chk("lhu_value", wb_data, 32'h0000_8001);
        run_load("lh_low",      3'd2, 32'h0000_0100, 1, 1, 32'h1234_F00D);
        run_load("lbu_b1",      3'd5, 32'h0000_0201, 0, 3, 32'h0000_9A00);
        run_load("lw_timeout",  3'd1, 32'h0000_0010, 0, -1, 32'h0);
        run_load("op7_illegal", 3'd7, 32'h0000_0040, 0, 0, 32'hDEAD_BEEF);
        run_load("op0_illegal", 3'd0, 32'h0000_0044, 0, 0, 32'hDEAD_BEEF);
        run_load("lw_mis",      3'd1, 32'h0000_0013, 0, 0, 32'hCAFE_F00D);
        run_load("lh_mis",      3'd2, 32'h0000_0021, 2, 1, 32'h8765_4321);

        for (int i = 0; i < 24; i++) begin
            run_load("rand", 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom);
        end

        // Reset while waiting for data, then a stale response arrives while idle.
        ld_valid = 1'b1; ld_op = 3'd1; ld_addr = 32'h0000_0080;
        tick();
        ld_valid = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick(); tick();
        chk("wait_stall", stall, 1'b1);
        chk("wait_no_req", mem_req, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            chk("post_reset_outputs", 32'(reset_outputs_ok()), 1);
            tick();
        end
        mem_rvalid = 1'b0;
        chk("post_reset_final", 32'(reset_outputs_ok()), 1);

        run_load("after_reset", 3'd4, 32'h0000_0302, 0, 1, 32'h00C3_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
